// File: rtl/i2s_rx_stereo.sv
// i2s_rx_stereo: stereo I2S / left-justified receiver with frame lock and framing-error detection.
// Define I2S_RX_ERRCNT_EN to build the saturating framing-error counter on err_cnt_o.
module i2s_rx_stereo #(
   parameter int WIDTH     = 16,
   parameter int SLOT_BITS = 16,
   parameter int MODE      = 0
) (
   input  logic             sclk_i,
   input  logic             rst_n_i,
   input  logic             ws_i,
   input  logic             sdata_i,
   output logic [WIDTH-1:0] left_o,
   output logic [WIDTH-1:0] right_o,
   output logic             valid_o,
   output logic             locked_o,
   output logic             frame_err_o,
   output logic [7:0]       err_cnt_o
);
   localparam int CW = $clog2(SLOT_BITS + 2);
   typedef enum logic [1:0] {UNLOCKED, SYNC, LOCKED} state_t;
   state_t           state, state_nxt;
   logic             ws_q;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    idx;
   logic [WIDTH-1:0] sh_l, sh_r, hold_l;
   logic             edge_det, err, ch, bit_ok, l_last, r_last, valid_nxt;
   // In MODE 0 the edge cycle still carries the previous slot's last bit.
   always_comb begin
      edge_det  = ws_i != ws_q;
      err       = edge_det && state != UNLOCKED && cnt != CW'(SLOT_BITS);
      ch        = (MODE == 1) ? ws_i : ws_q;
      idx       = (MODE == 1) ? (edge_det ? '0 : cnt) : cnt - CW'(1);
      bit_ok    = (MODE == 1 || cnt != '0) && idx < CW'(WIDTH);
      l_last    = bit_ok && !ch && idx == CW'(WIDTH - 1);
      r_last    = bit_ok && ch && idx == CW'(WIDTH - 1);
      valid_nxt = r_last && !err && state != UNLOCKED;
   end
   always_ff @(posedge sclk_i or negedge rst_n_i)
      if (!rst_n_i) state <= UNLOCKED;
      else state <= state_nxt;
   // A falling edge always (re)starts sync, even when it also flags an error.
   always_comb
      state_nxt = (edge_det && !ws_i) ? ((state == UNLOCKED || err) ? SYNC : LOCKED)
                : err ? UNLOCKED : state;
   always_comb locked_o = state == LOCKED;
   always_ff @(posedge sclk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         ws_q        <= 1'b0;
         cnt         <= '0;
         sh_l        <= '0;
         sh_r        <= '0;
         hold_l      <= '0;
         left_o      <= '0;
         right_o     <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         ws_q <= ws_i;
         cnt  <= edge_det ? CW'(1) : (cnt == CW'(SLOT_BITS + 1)) ? cnt : cnt + CW'(1);
         if (bit_ok && !ch) sh_l <= {sh_l[WIDTH-2:0], sdata_i};
         if (bit_ok && ch) sh_r <= {sh_r[WIDTH-2:0], sdata_i};
         if (l_last) hold_l <= {sh_l[WIDTH-2:0], sdata_i};
         if (valid_nxt) begin
            left_o  <= hold_l;
            right_o <= {sh_r[WIDTH-2:0], sdata_i};
         end
         valid_o     <= valid_nxt;
         frame_err_o <= err;
      end
`ifdef I2S_RX_ERRCNT_EN
   always_ff @(posedge sclk_i or negedge rst_n_i)
      if (!rst_n_i) err_cnt_o <= '0;
      else err_cnt_o <= (err && err_cnt_o != 8'hFF) ? err_cnt_o + 8'd1 : err_cnt_o;
`else
   assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_i2s_rx_stereo.sv
// tb_i2s_rx_stereo: directed bench for an I2S-mode (16/16) and a left-justified (24/32) receiver.
module tb_i2s_rx_stereo;
`ifdef I2S_RX_ERRCNT_EN
   localparam int ERR_EN = 1;
`else
   localparam int ERR_EN = 0;
`endif
   logic sclk = 1'b0, rst_n = 1'b1;
   logic ws0 = 1'b0, sd0 = 1'b0, ws1 = 1'b0, sd1 = 1'b0, lb0 = 1'b0;
   logic [15:0] l0, r0;
   logic [23:0] l1, r1;
   logic v0, k0, e0, v1, k1, e1;
   logic [7:0] c0, c1;
   int tests = 0, fails = 0;
   always #5 sclk = ~sclk;
   i2s_rx_stereo #(.WIDTH(16), .SLOT_BITS(16), .MODE(0)) u0 (
      .sclk_i(sclk), .rst_n_i(rst_n), .ws_i(ws0), .sdata_i(sd0), .left_o(l0), .right_o(r0),
      .valid_o(v0), .locked_o(k0), .frame_err_o(e0), .err_cnt_o(c0));
   i2s_rx_stereo #(.WIDTH(24), .SLOT_BITS(32), .MODE(1)) u1 (
      .sclk_i(sclk), .rst_n_i(rst_n), .ws_i(ws1), .sdata_i(sd1), .left_o(l1), .right_o(r1),
      .valid_o(v1), .locked_o(k1), .frame_err_o(e1), .err_cnt_o(c1));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic edge0(input logic w);
      ws0 = w;
      sd0 = lb0;
      @(posedge sclk); #1;
   endtask
   task automatic body0(input logic w, input logic [15:0] word, input int n);
      for (int i = 1; i < n; i++) begin
         ws0 = w;
         sd0 = (i <= 16) ? word[16-i] : 1'b0;
         @(posedge sclk); #1;
      end
      lb0 = (n <= 16) ? word[16-n] : 1'b0;
   endtask
   task automatic head1(input logic w, input logic [23:0] word);
      for (int i = 0; i < 24; i++) begin
         ws1 = w;
         sd1 = word[23-i];
         @(posedge sclk); #1;
      end
   endtask
   task automatic tail1(input logic w, input int n);
      for (int i = 0; i < n; i++) begin
         ws1 = w;
         sd1 = 1'b1;
         @(posedge sclk); #1;
      end
   endtask
   initial begin
      ws0 = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge sclk);
      #1;
      chk("rst_left", l0, 0);
      chk("rst_right", r0, 0);
      chk("rst_valid", v0, 0);
      chk("rst_locked", k0, 0);
      chk("rst_err", e0, 0);
      chk("rst_cnt", c0, 0);
      chk("rst_left1", l1, 0);
      rst_n = 1'b1;
      edge0(1); body0(1, 16'hFFFF, 16);
      chk("unlocked_valid", v0, 0);
      edge0(0);
      chk("trigger_valid", v0, 0);
      chk("trigger_locked", k0, 0);
      body0(0, 16'h1111, 16);
      edge0(1);
      chk("sync_rise_err", e0, 0);
      body0(1, 16'h2222, 16);
      edge0(0);
      chk("sync_valid", v0, 1);
      chk("sync_locked", k0, 1);
      chk("sync_left", l0, 16'h1111);
      chk("sync_right", r0, 16'h2222);
      body0(0, 16'hA5A5, 16);
      chk("valid_one_cycle", v0, 0);
      edge0(1); body0(1, 16'h1234, 16);
      chk("no_early_valid", v0, 0);
      edge0(0);
      chk("a5_valid", v0, 1);
      chk("a5_left", l0, 16'hA5A5);
      chk("a5_right", r0, 16'h1234);
      chk("a5_locked", k0, 1);
      body0(0, 16'h5A5A, 15);
      edge0(1);
      chk("short_err", e0, 1);
      chk("short_locked", k0, 0);
      chk("short_valid", v0, 0);
      chk("short_left_hold", l0, 16'hA5A5);
      chk("short_right_hold", r0, 16'h1234);
      chk("short_cnt", c0, ERR_EN);
      body0(1, 16'h0F0F, 16);
      chk("err_one_cycle", e0, 0);
      edge0(0);
      chk("resync_valid", v0, 0);
      chk("resync_locked", k0, 0);
      body0(0, 16'h3C3C, 16);
      edge0(1); body0(1, 16'hC3C3, 16);
      edge0(0);
      chk("relock_valid", v0, 1);
      chk("relock_locked", k0, 1);
      chk("relock_left", l0, 16'h3C3C);
      chk("relock_right", r0, 16'hC3C3);
      body0(0, 16'h7777, 16);
      edge0(1); body0(1, 16'h8888, 8);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_left", l0, 0);
      chk("arst_right", r0, 0);
      chk("arst_locked", k0, 0);
      chk("arst_cnt", c0, 0);
      @(posedge sclk); #1;
      rst_n = 1'b1;
      body0(1, 16'h8888, 8);
      edge0(0);
      chk("post_rst_valid", v0, 0);
      body0(0, 16'h1357, 16);
      edge0(1); body0(1, 16'h2468, 16);
      chk("post_rst_hold", r0, 0);
      edge0(0);
      chk("post_rst_frame_valid", v0, 1);
      chk("post_rst_left", l0, 16'h1357);
      chk("post_rst_right", r0, 16'h2468);
      for (int s = 0; s < 600; s++)
         for (int c = 0; c < 5; c++) begin
            ws0 = (s % 2 == 0) ? 1'b1 : 1'b0;
            sd0 = 1'b0;
            @(posedge sclk); #1;
            if (s == 0 && c == 0) begin
               chk("bad_first_err", e0, 1);
               chk("bad_first_locked", k0, 0);
            end
         end
      chk("bad_cnt_sat", c0, ERR_EN ? 255 : 0);
      chk("bad_valid", v0, 0);
      tail1(1, 32);
      head1(0, 24'h123456); tail1(0, 8);
      head1(1, 24'h654321);
      chk("lj_sync_valid", v1, 1);
      chk("lj_sync_left", l1, 24'h123456);
      chk("lj_sync_right", r1, 24'h654321);
      tail1(1, 8);
      head1(0, 24'h800001);
      chk("lj_locked", k1, 1);
      chk("lj_mid_valid", v1, 0);
      tail1(0, 8);
      head1(1, 24'h7FFFFE);
      chk("lj_valid", v1, 1);
      chk("lj_left", l1, 24'h800001);
      chk("lj_right", r1, 24'h7FFFFE);
      tail1(1, 8);
      chk("lj_valid_drop", v1, 0);
      chk("lj_right_hold", r1, 24'h7FFFFE);
      chk("lj_err", e1, 0);
      chk("lj_cnt", c1, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
